sdram_device_emu: RTL and testbench

- Synthesizable, cycle-based responder for the SDRAM pin interface driven by sdram_core_32bit; it replaces the external x16 SDRAM chip.
- Decodes CS/RAS/CAS/WE commands, tracks open rows per bank, honours the mode register (CAS latency, burst length) and serves reads/writes from an internal scaled-down array.
- Used for FPGA loopback and fast sims without the vendor behavioural model; flags protocol violations.

---
 rtl/sdram_emu_pkg.sv | 50 +++++
 rtl/sdram_emu_bank.sv | 69 ++++++
 rtl/sdram_device_emu.sv | 253 +++++++++++++++++++++++++
 tb/tb_sdram_device_emu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_emu_pkg.sv
// Shared types for the SDRAM device emulator: command and error encodings,
// mode-register field positions and the pin-level command decoder.
package sdram_emu_pkg;

  typedef enum logic [3:0] {
    CMD_INHIBIT,
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_AUTO_REFRESH,
    CMD_LOAD_MODE,
    CMD_BURST_TERM
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_NOINIT = 3'd1,
    ERR_STATE  = 3'd2,
    ERR_MODE   = 3'd3,
    ERR_BUS    = 3'd4,
    ERR_TIMING = 3'd5
  } err_t;

  localparam int unsigned MODE_BL_LSB = 0;
  localparam int unsigned MODE_CL_LSB = 4;
  localparam int unsigned ADDR_AP_BIT = 10;

  function automatic cmd_t decode_cmd(input logic cs, input logic ras,
                                      input logic cas, input logic we);
    cmd_t c;
    if (cs) begin
      c = CMD_INHIBIT;
    end else begin
      case ({ras, cas, we})
        3'b111:  c = CMD_NOP;
        3'b011:  c = CMD_ACTIVE;
        3'b101:  c = CMD_READ;
        3'b100:  c = CMD_WRITE;
        3'b010:  c = CMD_PRECHARGE;
        3'b001:  c = CMD_AUTO_REFRESH;
        3'b000:  c = CMD_LOAD_MODE;
        default: c = CMD_BURST_TERM;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdram_emu_bank.sv
// Per-bank state: open flag, open row, pending auto-precharge and, when
// SDRAM_EMU_TIMING_CHECK_EN is defined, tRCD/tRP down-counters.
module sdram_emu_bank #(
  parameter int unsigned ROW_W = 4,
  parameter int unsigned T_RCD = 2,
  parameter int unsigned T_RP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic             activate,
  input  logic             close,
  input  logic             rw_start,
  input  logic             ap_in,
  input  logic [ROW_W-1:0] row_in,
  output logic             is_open,
  output logic [ROW_W-1:0] row,
  output logic             ap_pending,
  output logic             rcd_busy,
  output logic             rp_busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_open    <= 1'b0;
      row        <= '0;
      ap_pending <= 1'b0;
    end else if (cke) begin
      if (close) begin
        is_open    <= 1'b0;
        ap_pending <= 1'b0;
      end else if (activate) begin
        is_open    <= 1'b1;
        row        <= row_in;
        ap_pending <= 1'b0;
      end else if (rw_start) begin
        ap_pending <= ap_in;
      end
    end
  end

`ifdef SDRAM_EMU_TIMING_CHECK_EN
  // Counters load with T-1 so a command exactly T cycles later sees zero.
  localparam logic [7:0] RCD_LD = (T_RCD > 0) ? 8'(T_RCD - 1) : 8'd0;
  localparam logic [7:0] RP_LD  = (T_RP > 0) ? 8'(T_RP - 1) : 8'd0;
  logic [7:0] rcd_cnt;
  logic [7:0] rp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_cnt <= '0;
      rp_cnt  <= '0;
    end else if (cke) begin
      if (activate) rcd_cnt <= RCD_LD;
      else if (rcd_cnt != '0) rcd_cnt <= rcd_cnt - 8'd1;
      if (close) rp_cnt <= RP_LD;
      else if (rp_cnt != '0) rp_cnt <= rp_cnt - 8'd1;
    end
  end

  assign rcd_busy = (rcd_cnt != '0);
  assign rp_busy  = (rp_cnt != '0);
`else
  localparam int unsigned unused_timing_cfg = T_RCD + T_RP;
  assign rcd_busy = 1'b0;
  assign rp_busy  = 1'b0;
`endif

endmodule

// File: rtl/sdram_device_emu.sv
// Cycle-based x16 SDRAM device responder with mode register, 4 banks and
// protocol checking; SDRAM_EMU_TIMING_CHECK_EN adds tRCD/tRP/tRFC checks.
module sdram_device_emu
  import sdram_emu_pkg::*;
#(
  parameter int unsigned ROW_W = 4,
  parameter int unsigned COL_W = 9,
  parameter int unsigned T_RCD = 2,
  parameter int unsigned T_RP  = 2,
  parameter int unsigned T_RFC = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sdram_cke_i,
  input  logic        sdram_cs_i,
  input  logic        sdram_ras_i,
  input  logic        sdram_cas_i,
  input  logic        sdram_we_i,
  input  logic [1:0]  sdram_dqm_i,
  input  logic [12:0] sdram_addr_i,
  input  logic [1:0]  sdram_ba_i,
  input  logic [15:0] sdram_data_i,
  input  logic        sdram_data_out_en_i,
  output logic [15:0] sdram_data_o,
  output logic        rd_valid_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  localparam int unsigned IDX_W = 2 + ROW_W + COL_W;

  cmd_t             cmd;
  logic             a10;
  logic             mode_valid, cl3;
  logic [1:0]       bl_log;
  logic [2:0]       bl_mask;
  logic [COL_W-1:0] col_mask;
  logic             bl_ok, cl_ok;

  logic [3:0]       bank_open, bank_ap, rcd_busy, rp_busy;
  logic [ROW_W-1:0] bank_row [4];
  logic [3:0]       act_en, close_en, rw_start_en;

  logic             burst_active, burst_wr;
  logic [1:0]       burst_ba;
  logic [ROW_W-1:0] burst_row;
  logic [COL_W-1:0] burst_col;
  logic [2:0]       burst_off;

  logic             act_ok, rw_ok, mode_ld, trunc, ap_now, timing_viol;
  logic             issue, issue_wr, issue_last;
  logic [1:0]       issue_ba;
  logic [ROW_W-1:0] issue_row;
  logic [COL_W-1:0] issue_col;
  logic [IDX_W-1:0] idx;
  logic [5:1]       err_flags;
  err_t             first_err;

  logic [15:0]      mem [2**IDX_W];
  logic [15:0]      rd_q, s2_d;
  logic             s1_v, s2_v;
  logic             unused_addr;

  assign cmd         = decode_cmd(sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i);
  assign a10         = sdram_addr_i[ADDR_AP_BIT];
  assign bl_mask     = 3'((4'd1 << bl_log) - 4'd1);
  assign col_mask    = COL_W'(bl_mask);
  assign bl_ok       = (sdram_addr_i[MODE_BL_LSB +: 3] <= 3'd3);
  assign cl_ok       = (sdram_addr_i[MODE_CL_LSB +: 3] == 3'd2) ||
                       (sdram_addr_i[MODE_CL_LSB +: 3] == 3'd3);
  assign idx         = {issue_ba, issue_row, issue_col};
  assign unused_addr = ^sdram_addr_i;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_emu_bank #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP)) u_bank (
      .clk       (clk_i),
      .rst       (rst_i),
      .cke       (sdram_cke_i),
      .activate  (act_en[b]),
      .close     (close_en[b]),
      .rw_start  (rw_start_en[b]),
      .ap_in     (a10),
      .row_in    (sdram_addr_i[ROW_W-1:0]),
      .is_open   (bank_open[b]),
      .row       (bank_row[b]),
      .ap_pending(bank_ap[b]),
      .rcd_busy  (rcd_busy[b]),
      .rp_busy   (rp_busy[b])
    );
  end

  always_comb begin
    err_flags   = '0;
    act_ok      = 1'b0;
    rw_ok       = 1'b0;
    mode_ld     = 1'b0;
    case (cmd)
      CMD_ACTIVE: begin
        if (!mode_valid) err_flags[1] = 1'b1;
        else if (bank_open[sdram_ba_i]) err_flags[2] = 1'b1;
        else act_ok = 1'b1;
      end
      CMD_READ, CMD_WRITE: begin
        if (!mode_valid) err_flags[1] = 1'b1;
        else if (!bank_open[sdram_ba_i]) err_flags[2] = 1'b1;
        else rw_ok = 1'b1;
      end
      CMD_LOAD_MODE: begin
        if (|bank_open) err_flags[2] = 1'b1;
        else mode_ld = 1'b1;
        if (!(bl_ok && cl_ok)) err_flags[3] = 1'b1;
      end
      CMD_AUTO_REFRESH: if (|bank_open) err_flags[2] = 1'b1;
      default: ;
    endcase

    trunc = (cmd == CMD_BURST_TERM) ||
            ((cmd == CMD_PRECHARGE) && (a10 || (sdram_ba_i == burst_ba)));

    // An accepted READ/WRITE issues its first word in the same cycle and
    // pre-empts whatever is left of the running burst.
    issue      = 1'b0;
    issue_wr   = 1'b0;
    issue_ba   = sdram_ba_i;
    issue_row  = bank_row[sdram_ba_i];
    issue_col  = sdram_addr_i[COL_W-1:0];
    issue_last = 1'b0;
    ap_now     = bank_ap[burst_ba];
    if (rw_ok) begin
      issue      = 1'b1;
      issue_wr   = (cmd == CMD_WRITE);
      issue_last = (bl_mask == 3'd0);
      ap_now     = a10;
    end else if (burst_active && !trunc) begin
      issue      = 1'b1;
      issue_wr   = burst_wr;
      issue_ba   = burst_ba;
      issue_row  = burst_row;
      issue_col  = (burst_col & ~col_mask) | ((burst_col + COL_W'(burst_off)) & col_mask);
      issue_last = (burst_off == bl_mask);
    end

    if (issue && issue_wr && !sdram_data_out_en_i) err_flags[4] = 1'b1;
    err_flags[5] = timing_viol;

    close_en = '0;
    if (cmd == CMD_PRECHARGE) close_en = a10 ? 4'b1111 : (4'b0001 << sdram_ba_i);
    if (issue && issue_last && ap_now) close_en[issue_ba] = 1'b1;
    if (burst_active && bank_ap[burst_ba] &&
        (trunc || (rw_ok && (sdram_ba_i != burst_ba))))
      close_en[burst_ba] = 1'b1;

    act_en      = act_ok ? (4'b0001 << sdram_ba_i) : 4'b0000;
    rw_start_en = rw_ok  ? (4'b0001 << sdram_ba_i) : 4'b0000;

    first_err = ERR_NONE;
    if (err_flags[5]) first_err = ERR_TIMING;
    if (err_flags[4]) first_err = ERR_BUS;
    if (err_flags[3]) first_err = ERR_MODE;
    if (err_flags[2]) first_err = ERR_STATE;
    if (err_flags[1]) first_err = ERR_NOINIT;
  end

`ifdef SDRAM_EMU_TIMING_CHECK_EN
  localparam logic [7:0] RFC_LD = (T_RFC > 0) ? 8'(T_RFC - 1) : 8'd0;
  logic [7:0] rfc_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rfc_cnt <= '0;
    else if (sdram_cke_i) begin
      if (cmd == CMD_AUTO_REFRESH) rfc_cnt <= RFC_LD;
      else if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - 8'd1;
    end
  end

  assign timing_viol = ((cmd == CMD_ACTIVE) && rp_busy[sdram_ba_i]) ||
                       (((cmd == CMD_READ) || (cmd == CMD_WRITE)) && rcd_busy[sdram_ba_i]) ||
                       ((rfc_cnt != '0) && (cmd != CMD_NOP) && (cmd != CMD_INHIBIT));
`else
  localparam int unsigned unused_rfc = T_RFC;
  logic unused_timing;
  assign unused_timing = ^{rcd_busy, rp_busy};
  assign timing_viol   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_valid   <= 1'b0;
      cl3          <= 1'b1;
      bl_log       <= 2'd0;
      burst_active <= 1'b0;
      burst_wr     <= 1'b0;
      burst_ba     <= '0;
      burst_row    <= '0;
      burst_col    <= '0;
      burst_off    <= '0;
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s2_d         <= '0;
      sdram_data_o <= '0;
      rd_valid_o   <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
    end else if (sdram_cke_i) begin
      if ((err_flags != '0) && !err_o) begin
        err_o      <= 1'b1;
        err_code_o <= first_err;
      end
      if (mode_ld) begin
        mode_valid <= 1'b1;
        if (bl_ok) bl_log <= sdram_addr_i[MODE_BL_LSB +: 2];
        if (cl_ok) cl3 <= sdram_addr_i[MODE_CL_LSB];
      end

      if (rw_ok) begin
        burst_active <= !issue_last;
        burst_wr     <= (cmd == CMD_WRITE);
        burst_ba     <= sdram_ba_i;
        burst_row    <= bank_row[sdram_ba_i];
        burst_col    <= sdram_addr_i[COL_W-1:0];
        burst_off    <= 3'd1;
      end else if (issue) begin
        burst_active <= !issue_last;
        burst_off    <= burst_off + 3'd1;
      end else if (trunc) begin
        burst_active <= 1'b0;
      end

      // rd_q is the first latency stage; CL3 inserts one more register.
      s1_v <= issue && !issue_wr;
      s2_v <= cl3 && s1_v;
      s2_d <= rd_q;
      if (cl3) begin
        rd_valid_o <= s2_v;
        if (s2_v) sdram_data_o <= s2_d;
      end else begin
        rd_valid_o <= s1_v;
        if (s1_v) sdram_data_o <= rd_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sdram_cke_i) begin
      if (issue && issue_wr && sdram_data_out_en_i) begin
        if (!sdram_dqm_i[0]) mem[idx][7:0]  <= sdram_data_i[7:0];
        if (!sdram_dqm_i[1]) mem[idx][15:8] <= sdram_data_i[15:8];
      end
      rd_q <= mem[idx];
    end
  end

endmodule

// File: tb/tb_sdram_device_emu.sv
// Scoreboard bench for sdram_device_emu: a word-addressed memory model
// predicts read bursts; a negedge monitor pops and compares them.
module tb_sdram_device_emu;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_LMR   = 4'b0000;
  localparam logic [3:0] C_BST   = 4'b0110;

  logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
  logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  dqm = '0, ba = '0;
  logic [12:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        doe = 1'b0;
  logic [15:0] rdata;
  logic        rd_valid, err;
  logic [2:0]  err_code;

  sdram_device_emu dut (
    .clk_i(clk), .rst_i(rst), .sdram_cke_i(cke), .sdram_cs_i(cs),
    .sdram_ras_i(ras), .sdram_cas_i(cas), .sdram_we_i(we), .sdram_dqm_i(dqm),
    .sdram_addr_i(addr), .sdram_ba_i(ba), .sdram_data_i(wdata),
    .sdram_data_out_en_i(doe), .sdram_data_o(rdata), .rd_valid_o(rd_valid),
    .err_o(err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0, n_chk = 0;
  typedef struct { int due; logic [15:0] d; } exp_t;
  exp_t sb[$];

  logic [15:0] mem_m [int];
  int          row_m [4];
  int          cl_m = 3, bl_m = 1;
  logic [15:0] wd [8];
  logic [1:0]  wm [8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rd_valid", int'(rd_valid), 1);
        check("rd_data", int'(rdata), int'(e.d));
      end else if (rd_valid) begin
        check("rd_valid_spurious", int'(rd_valid), 0);
      end
    end
  end

  function automatic int midx(input int b, input int r, input int c);
    return b * 8192 + r * 512 + c;
  endfunction

  function automatic int wcol(input int base, input int k);
    return (base / bl_m) * bl_m + (base + k) % bl_m;
  endfunction

  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    @(negedge clk);
    {cs, ras, cas, we} = c;
    ba   = b;
    addr = a;
  endtask

  task automatic nop(input int n);
    repeat (n) drive(C_NOP, 2'd0, 13'd0);
  endtask

  task automatic do_load(input int a);
    drive(C_LMR, 2'd0, 13'(a));
    cl_m = (a >> 4) & 7;
    bl_m = 1 << (a & 7);
    nop(1);
  endtask

  task automatic do_act(input int b, input int r);
    drive(C_ACT, 2'(b), 13'(r));
    row_m[b] = r;
    nop(2);
  endtask

  task automatic do_pre_all();
    drive(C_PRE, 2'd0, 13'h400);
    nop(2);
  endtask

  task automatic do_write(input int b, input int col);
    int i;
    logic [15:0] old;
    for (int k = 0; k < bl_m; k++) begin
      drive(k == 0 ? C_WRITE : C_NOP, 2'(b), 13'(col));
      wdata = wd[k];
      dqm   = wm[k];
      doe   = 1'b1;
      i   = midx(b, row_m[b], wcol(col, k));
      old = mem_m.exists(i) ? mem_m[i] : 16'h0000;
      if (!wm[k][0]) old[7:0]  = wd[k][7:0];
      if (!wm[k][1]) old[15:8] = wd[k][15:8];
      mem_m[i] = old;
    end
    drive(C_NOP, 2'd0, 13'd0);
    doe = 1'b0;
    dqm = '0;
  endtask

  task automatic push_word(input int n, input int b, input int col, input int k);
    exp_t e;
    e.due = n + cl_m - 1 + k;
    e.d   = mem_m[midx(b, row_m[b], wcol(col, k))];
    sb.push_back(e);
  endtask

  task automatic do_read(input int b, input int col);
    int n;
    drive(C_READ, 2'(b), 13'(col));
    n = cyc + 1;
    for (int k = 0; k < bl_m; k++) push_word(n, b, col, k);
    nop(bl_m - 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() > 0; t++) nop(1);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int n, exp_code;
    exp_code = 2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data", int'(rdata), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_err", int'(err), 0);
    check("reset_err_code", int'(err_code), 0);

    // CL2 BL2 write then read
    do_load('h021);
    do_act(1, 3);
    wd[0] = 16'hBEEF; wd[1] = 16'h1234; wm[0] = 2'b00; wm[1] = 2'b00;
    do_write(1, 'h10);
    check("err_after_write", int'(err), 0);
    do_read(1, 'h10);
    drain();

    // CL3 shifts the burst by one cycle
    do_pre_all();
    do_load('h031);
    do_act(1, 3);
    do_read(1, 'h10);
    drain();

    // byte-masked write: low byte only into 0x11, 0x10 fully masked
    wd[0] = 16'hAAAA; wd[1] = 16'h5555; wm[0] = 2'b10; wm[1] = 2'b11;
    do_write(1, 'h11);
    do_read(1, 'h10);
    drain();
    check("model_masked_word", int'(mem_m[midx(1, 3, 'h11)]), 'h12AA);

    // BL4 wrap within the aligned block
    do_pre_all();
    do_load('h032);
    do_act(1, 3);
    for (int k = 0; k < 4; k++) begin wd[k] = 16'hA0A0 + 16'(k); wm[k] = 2'b00; end
    do_write(1, 'h0C);
    do_read(1, 'h0E);
    drain();

    // BURST_TERM one cycle after READ leaves only the first word
    drive(C_READ, 2'd1, 13'h0C);
    n = cyc + 1;
    push_word(n, 1, 'h0C, 0);
    drive(C_BST, 2'd0, 13'd0);
    nop(4);
    drain();
    check("err_after_directed", int'(err), 0);

    // randomized modes and read/write traffic
    for (int m = 0; m < 3; m++) begin
      do_pre_all();
      do_load(($urandom_range(2, 3) << 4) | $urandom_range(0, 3));
      for (int b = 0; b < 4; b++) do_act(b, $urandom_range(0, 15));
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 16; c += bl_m) begin
          for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'b00; end
          do_write(b, c);
        end
      for (int op = 0; op < 25; op++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'($urandom); end
          do_write($urandom_range(0, 3), $urandom_range(0, 15));
        end else begin
          do_read($urandom_range(0, 3), $urandom_range(0, 15));
        end
      end
      drain();
    end
    check("err_after_random", int'(err), 0);

`ifdef SDRAM_EMU_TIMING_CHECK_EN
    do_pre_all();
    do_act(0, 5);
    for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'b00; end
    do_write(0, 0);
    drive(C_PRE, 2'd0, 13'd0);
    nop(2);
    drive(C_ACT, 2'd0, 13'd5);
    do_read(0, 0);
    drain();
    check("timing_err", int'(err), 1);
    check("timing_err_code", int'(err_code), 5);
    exp_code = 5;
`endif

    // READ to an idle bank, then a bad mode word must not overwrite the code
    do_pre_all();
    drive(C_READ, 2'd2, 13'h010);
    nop(6);
    check("idle_read_err", int'(err), 1);
    check("idle_read_code", int'(err_code), exp_code);
    drive(C_LMR, 2'd0, 13'h077);
    nop(2);
    check("sticky_err", int'(err), 1);
    check("sticky_code", int'(err_code), exp_code);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
